// File: rtl/scope_capture.sv
// scope_capture: triggered oscilloscope capture into a double-banked sample RAM
//
// Macro: SCOPE_CAPTURE_AUTO_EN enables the auto-trigger timeout in WAIT and
//        drives o_trig_auto; when undefined WAIT holds until a real trigger.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_run               level: re-arm after every displayed capture
//   i_single            pulse: arm one capture from IDLE
//   i_stop              pulse: abandon capture / discard finished capture
//   i_sample_en         sample strobe (decimation)
//   i_data              ADC sample
//   i_trig_level        trigger threshold
//   i_trig_rise         1 = rising-edge trigger, 0 = falling-edge trigger
//   i_swap              display frame boundary; a finished capture may swap in
//   o_wr_en/_addr/_data registered RAM write port
//   o_wr_bank           bank being written; the display reads the other one
//   o_disp_start        address of the oldest sample in the displayed bank
//   o_busy, o_done      capture in progress / capture waiting for a swap
//   o_trig_auto         last swapped capture was auto-triggered
module scope_capture #(
    parameter int  DATA_W       = 8,
    parameter int  DEPTH        = 512,
    parameter int  PRE_DEPTH    = 128,
    parameter int  AUTO_TIMEOUT = 4096,
    localparam int AW           = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_run,
    input  logic              i_single,
    input  logic              i_stop,
    input  logic              i_sample_en,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_trig_level,
    input  logic              i_trig_rise,
    input  logic              i_swap,
    output logic              o_wr_en,
    output logic [AW-1:0]     o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_wr_bank,
    output logic [AW-1:0]     o_disp_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_trig_auto
);
    localparam int          CW     = AW + 1;
    localparam logic [AW:0] PRE_N  = CW'(PRE_DEPTH);
    localparam logic [AW:0] POST_N = CW'(DEPTH - PRE_DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || PRE_DEPTH < 0 || PRE_DEPTH >= DEPTH
        || AUTO_TIMEOUT < 1) begin : g_bad_cfg
        $error("scope_capture: illegal DEPTH/PRE_DEPTH/AUTO_TIMEOUT");
    end

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d;
    logic [AW:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic [AW-1:0]       trig_addr_q, trig_addr_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                bank_q, bank_d;
    logic [AW-1:0]       disp_start_q, disp_start_d;
    logic                busy, strobe, trig_hit, timeout, fire, pre_last, post_last;
    logic                enter_pre, swap;

    assign busy      = state_q == S_PRE || state_q == S_WAIT || state_q == S_POST;
    // A stop cancels any write it coincides with.
    assign strobe    = i_sample_en && busy && !i_stop;
    assign trig_hit  = i_trig_rise ? (prev_q < i_trig_level && i_data >= i_trig_level)
                                   : (prev_q > i_trig_level && i_data <= i_trig_level);
    // Only WAIT evaluates the trigger, so a crossing on the strobe that
    // completes PRE is never seen.
    assign fire      = state_q == S_WAIT && strobe && (trig_hit || timeout);
    assign pre_last  = cnt_q + CW'(1) == PRE_N;
    assign post_last = cnt_q + CW'(1) == POST_N;
    assign swap      = state_q == S_DONE && i_swap && !i_stop;
    assign enter_pre = state_d == S_PRE && state_q != S_PRE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_stop) state_d = S_IDLE;
        else begin
            case (state_q)
                S_IDLE:  if (i_single || i_run) state_d = S_PRE;
                S_PRE:   if (PRE_DEPTH == 0 || (strobe && pre_last)) state_d = S_WAIT;
                // The trigger sample is the first POST sample, so a one-sample
                // post window finishes on the trigger itself.
                S_WAIT:  if (fire) state_d = POST_N == CW'(1) ? S_DONE : S_POST;
                S_POST:  if (strobe && post_last) state_d = S_DONE;
                S_DONE:  if (i_swap) state_d = i_run ? S_PRE : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_busy = busy;
        o_done = state_q == S_DONE;
    end

    always_comb begin
        ptr_d        = enter_pre ? '0 : strobe ? ptr_q + AW'(1) : ptr_q;
        prev_d       = enter_pre ? '0 : strobe ? i_data : prev_q;
        // Shared counter: PRE samples, then POST samples (trigger counts as 1).
        cnt_d        = (enter_pre || state_d == S_WAIT) ? '0
                     : fire ? CW'(1)
                     : strobe ? cnt_q + CW'(1) : cnt_q;
        trig_addr_d  = fire ? ptr_q : trig_addr_q;
        wr_en_d      = strobe;
        wr_addr_d    = strobe ? ptr_q : wr_addr_q;
        wr_data_d    = strobe ? i_data : wr_data_q;
        bank_d       = swap ? !bank_q : bank_q;
        disp_start_d = swap ? trig_addr_q - AW'(PRE_DEPTH) : disp_start_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_q        <= '0;
            cnt_q        <= '0;
            prev_q       <= '0;
            trig_addr_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            bank_q       <= 1'b0;
            disp_start_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            trig_addr_q  <= trig_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            bank_q       <= bank_d;
            disp_start_q <= disp_start_d;
        end
    end

`ifdef SCOPE_CAPTURE_AUTO_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          auto_pend_q, auto_pend_d, trig_auto_q, trig_auto_d;

    // The AUTO_TIMEOUT-th untriggered WAIT strobe becomes the trigger sample.
    assign timeout = to_cnt_q == TW'(AUTO_TIMEOUT - 1);

    always_comb begin
        to_cnt_d    = state_q != S_WAIT ? '0 : strobe ? to_cnt_q + TW'(1) : to_cnt_q;
        auto_pend_d = fire ? !trig_hit : auto_pend_q;
        trig_auto_d = swap ? auto_pend_q : trig_auto_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            to_cnt_q    <= '0;
            auto_pend_q <= 1'b0;
            trig_auto_q <= 1'b0;
        end else begin
            to_cnt_q    <= to_cnt_d;
            auto_pend_q <= auto_pend_d;
            trig_auto_q <= trig_auto_d;
        end
    end

    assign o_trig_auto = trig_auto_q;
`else
    assign timeout     = 1'b0;
    assign o_trig_auto = 1'b0;
`endif

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_bank    = bank_q;
    assign o_disp_start = disp_start_q;
endmodule

// File: doc/scope_capture.md
SCOPE_CAPTURE -- requirements
Module: scope_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8: sample width.
REQ-002 SHALL have parameter DEPTH, default 512: samples per bank; power of 2; AW = log2(DEPTH).
REQ-003 SHALL have parameter PRE_DEPTH, default 128: pre-trigger samples; range 0..DEPTH-1.
REQ-004 SHALL have parameter AUTO_TIMEOUT, default 4096: auto-trigger sample count (used only with the macro).
REQ-005 SHALL have port i_clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_run, input, 1: level; continuous re-arm while high.
REQ-008 SHALL have port i_single, input, 1: pulse; arms one capture.
REQ-009 SHALL have port i_stop, input, 1: pulse; abort capture.
REQ-010 SHALL have port i_sample_en, input, 1: sample strobe (decimation).
REQ-011 SHALL have port i_data, input, DATA_W: ADC sample.
REQ-012 SHALL have port i_trig_level, input, DATA_W: trigger threshold.
REQ-013 SHALL have port i_trig_rise, input, 1: 1 = rising edge, 0 = falling edge.
REQ-014 SHALL have port i_swap, input, 1: display frame-boundary pulse; bank swap allowed.
REQ-015 SHALL have port o_wr_en, output, 1: RAM write strobe.
REQ-016 SHALL have port o_wr_addr, output, AW: RAM write address.
REQ-017 SHALL have port o_wr_data, output, DATA_W: RAM write data.
REQ-018 SHALL have port o_wr_bank, output, 1: bank being written; the display reads !o_wr_bank.
REQ-019 SHALL have port o_disp_start, output, AW: oldest sample address of the displayed bank.
REQ-020 SHALL have port o_busy, output, 1: state is PRE, WAIT, or POST.
REQ-021 SHALL have port o_done, output, 1: state is DONE.
REQ-022 SHALL have port o_trig_auto, output, 1: last swapped capture was auto-triggered.

Function
REQ-023 SHALL implement states IDLE, PRE, WAIT, POST, DONE.
REQ-024 IDLE: i_single or i_run high -> PRE; write pointer <= 0; pre counter <= 0.
REQ-025 PRE: each strobe writes; after PRE_DEPTH strobes -> WAIT (PRE_DEPTH=0 -> WAIT next cycle).
REQ-026 WAIT: each strobe writes; a trigger (REQ-027) -> POST; trigger address T = that sample's address.
REQ-027 Trigger SHALL be: rising = prev<level && cur>=level; falling = prev>level && cur<=level; prev = last strobed sample, cleared to 0 on entering PRE.
REQ-028 POST: DEPTH-PRE_DEPTH samples written including the trigger sample, then -> DONE.
REQ-029 Write SHALL register: strobe in cycle n -> o_wr_en=1, o_wr_addr=ptr, o_wr_data=i_data in cycle n+1; ptr increments mod DEPTH (wraps 511->0).
REQ-030 DONE: on i_swap, SHALL toggle o_wr_bank, set o_disp_start <= (T-PRE_DEPTH) mod DEPTH, update o_trig_auto, then -> PRE if i_run high, else -> IDLE.
REQ-031 No write SHALL occur in IDLE or DONE; strobes there are ignored.
REQ-032 i_stop in PRE/WAIT/POST SHALL go to IDLE with no swap; i_stop in DONE SHALL discard the capture (no swap) and go to IDLE; i_stop wins over a simultaneous trigger, swap, or arm.
REQ-033 i_single while busy or in DONE SHALL be ignored.
REQ-034 Trigger and final POST sample on the same strobe as PRE completion: PRE->WAIT takes precedence; trigger is evaluated from the next strobe.

Reset
REQ-035 i_rst_n low SHALL asynchronously force: state IDLE, all outputs 0, ptr 0, prev 0, counters 0.
REQ-036 Reset mid-capture SHALL abandon it; the first post-reset capture writes bank 0.

Configuration
REQ-037 SCOPE_CAPTURE_AUTO_EN defined: in WAIT, after AUTO_TIMEOUT strobes without a trigger, SHALL force trigger at the current sample and mark it auto.
REQ-038 SCOPE_CAPTURE_AUTO_EN undefined: WAIT SHALL hold indefinitely; o_trig_auto SHALL be tied to 0; no timeout counter.

Verification
REQ-039 Defaults, i_single, i_sample_en=1, ramp 0..255 repeating, level 100, rise -> T at the first 100 after 128 pre samples; 384 post writes; swap -> o_disp_start=(T-128)&511, o_wr_bank=1.
REQ-040 i_run=1, 3 swaps -> o_wr_bank toggles 0->1->0->1; no writes occur in DONE.
REQ-041 i_stop during POST -> IDLE next cycle, o_wr_bank unchanged, o_done never asserted.
REQ-042 Constant data 50, level 100, AUTO_EN, AUTO_TIMEOUT=16 -> POST after 128+16 strobes; after swap o_trig_auto=1; without the macro, WAIT holds beyond 10000 cycles.
REQ-043 i_rst_n low mid-WAIT -> all outputs 0 immediately (asynchronous).
REQ-044 i_sample_en every 4th cycle, falling-edge trigger on a 255->0 step -> writes every 4 cycles; T at the 0 sample.
